// File: rtl/frame_config_sequencer_if.sv
// Word-stream handshake into the column frame-configuration sequencer.
// The master drives data/valid; the slave (sequencer) returns ready.
interface frame_config_sequencer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// Column frame-configuration write controller: takes a header word plus
// NumRows data words, assembles them on FrameData, then fires a timed
// one-hot FrameStrobe for the addressed frame. All outputs are registered
// and derived from the next state, so they line up with the state register.
module frame_config_sequencer #(
  parameter int          NumRows         = 4,
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          StrobeWidth     = 2,
  parameter logic [7:0]  SyncByte        = 8'hA5
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  frame_config_sequencer_if.slave              s_if,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  input  logic                                 err_clr
);

  localparam int         RcW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(NumRows - 1);
  localparam logic [3:0] ScLast = 4'(StrobeWidth - 1);
  localparam logic [5:0] MaxIdx = 6'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_DISCARD, ST_SETUP, ST_STROBE, ST_HOLD
  } state_t;

  state_t                                  state_q, state_d;
  logic [RcW-1:0]                          rc_q, rc_d;
  logic [3:0]                              sc_q, sc_d;
  logic [4:0]                              idx_q, idx_d;
  logic [NumRows-1:0][FrameBitsPerRow-1:0] frame_q, frame_d;
  logic                                    err_q, err_d;
  logic                                    ready_q, ready_d;
  logic [MaxFramesPerCol-1:0]              strobe_q, strobe_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic                                    acc;
  logic                                    is_hdr;

  assign acc    = s_if.s_valid && ready_q;
  assign is_hdr = (s_if.s_data[31:24] == SyncByte);

  // Next-state, datapath and registered-output precompute.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Non-sync words are swallowed here so junk never starts a frame.
        if (acc && is_hdr) begin
          idx_d = s_if.s_data[4:0];
          rc_d  = '0;
          if ({1'b0, s_if.s_data[4:0]} < MaxIdx) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DISCARD;
            err_d   = 1'b1;  // set beats a same-cycle clear
          end
        end
      end
      ST_LOAD: begin
        if (acc) begin
          frame_d[rc_q] = s_if.s_data;
          rc_d          = rc_q + 1'b1;
          if (rc_q == RcLast) begin
            rc_d    = '0;
            state_d = ST_SETUP;
          end
        end
      end
      ST_DISCARD: begin
        // Drain the payload of a bad frame so the stream stays aligned.
        if (acc) begin
          rc_d = rc_q + 1'b1;
          if (rc_q == RcLast) begin
            rc_d    = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SETUP: begin
        sc_d    = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (sc_q == ScLast) begin
          sc_d    = '0;
          state_d = ST_HOLD;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DISCARD);
    strobe_d = (state_d == ST_STROBE) ? (MaxFramesPerCol'(1) << idx_q) : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_HOLD);
  end

  // State and output registers; reset aborts any frame without a strobe.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      rc_q     <= '0;
      sc_q     <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      sc_q     <= sc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s_if.s_ready = ready_q;
  assign FrameData    = frame_q;
  assign FrameStrobe  = strobe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: a per-cycle vector table for
// the main flows, plus hand sequences for backpressure and mid-strobe reset.
module tb_frame_config_sequencer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         err_clr;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy, done, err;

  frame_config_sequencer_if sif ();

  frame_config_sequencer dut (
    .UserCLK    (clk),
    .resetn     (resetn),
    .s_if       (sif),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // FrameStrobe must never be multi-hot.
  always @(negedge clk) begin
    assert ($onehot0(FrameStrobe)) else $error("FAIL onehot strobe=%0h", FrameStrobe);
  end

  typedef struct {
    logic         rstn, vld;
    logic [31:0]  data;
    logic         clr;
    logic         rdy;
    logic [19:0]  stb;
    logic         dn, bsy, er;
    logic         chkfd;
    logic [127:0] fd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [127:0] F1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] F2 = 128'hF0F0F0F0_0F0F0F0F_89ABCDEF_01234567;
  localparam logic [127:0] F3 = 128'h77777777_66666666_55555555_A5000001;

  task automatic v(input logic rstn, input logic vld, input logic [31:0] data,
                   input logic clr, input logic rdy, input logic [19:0] stb,
                   input logic dn, input logic bsy, input logic er,
                   input logic chkfd = 1'b0, input logic [127:0] fd = '0);
    vec_t e;
    e.rstn = rstn; e.vld = vld; e.data = data; e.clr = clr;
    e.rdy = rdy; e.stb = stb; e.dn = dn; e.bsy = bsy; e.er = er;
    e.chkfd = chkfd; e.fd = fd;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Drive inputs for one cycle; return #1 after the edge for sampling.
  task automatic step(input logic rstn, input logic vld, input logic [31:0] data,
                      input logic clr);
    resetn = rstn; sif.s_valid = vld; sif.s_data = data; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string nm, input logic rdy, input logic [19:0] stb,
                      input logic dn, input logic bsy, input logic er);
    chk({nm, ".rdy"},  128'(sif.s_ready), 128'(rdy));
    chk({nm, ".stb"},  128'(FrameStrobe), 128'(stb));
    chk({nm, ".done"}, 128'(done),        128'(dn));
    chk({nm, ".busy"}, 128'(busy),        128'(bsy));
    chk({nm, ".err"},  128'(err),         128'(er));
  endtask

  task automatic word(input logic [31:0] w);
    step(1'b1, 1'b1, w, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0; err_clr = 1'b0;

    // reset, then single frame idx 3 back-to-back
    v(0,0,32'h0,0,            0,20'h0,0,0,0, 1,128'h0);
    v(1,0,32'h0,0,            1,20'h0,0,0,0);
    v(1,1,32'hA500_0003,0,    1,20'h0,0,1,0);
    v(1,1,32'h1111_1111,0,    1,20'h0,0,1,0, 1,{96'h0,32'h11111111});
    v(1,1,32'h2222_2222,0,    1,20'h0,0,1,0);
    v(1,1,32'h3333_3333,0,    1,20'h0,0,1,0);
    v(1,1,32'h4444_4444,0,    0,20'h0,0,1,0, 1,F1);
    v(1,0,32'h0,0,            0,20'h8,0,1,0);
    v(1,0,32'h0,0,            0,20'h8,0,1,0);
    v(1,0,32'h0,0,            0,20'h0,1,1,0, 1,F1);
    v(1,0,32'h0,0,            1,20'h0,0,0,0);
    // junk in IDLE
    v(1,1,32'h0000_0003,0,    1,20'h0,0,0,0);
    v(1,1,32'hFFFF_FFFF,0,    1,20'h0,0,0,0, 1,F1);
    // bad index 23: payload discarded, err set
    v(1,1,32'hA500_0017,0,    1,20'h0,0,1,1);
    v(1,1,32'hDEAD_BEEF,0,    1,20'h0,0,1,1);
    v(1,1,32'hDEAD_BEEF,0,    1,20'h0,0,1,1);
    v(1,1,32'hDEAD_BEEF,0,    1,20'h0,0,1,1);
    v(1,1,32'hDEAD_BEEF,0,    1,20'h0,0,0,1, 1,F1);
    v(1,0,32'h0,0,            1,20'h0,0,0,1);
    // valid frame idx 0 after a bad one; err stays sticky
    v(1,1,32'hA500_0000,0,    1,20'h0,0,1,1);
    v(1,1,32'h0123_4567,0,    1,20'h0,0,1,1);
    v(1,1,32'h89AB_CDEF,0,    1,20'h0,0,1,1);
    v(1,1,32'h0F0F_0F0F,0,    1,20'h0,0,1,1);
    v(1,1,32'hF0F0_F0F0,0,    0,20'h0,0,1,1, 1,F2);
    v(1,0,32'h0,0,            0,20'h1,0,1,1);
    v(1,0,32'h0,0,            0,20'h1,0,1,1);
    v(1,0,32'h0,0,            0,20'h0,1,1,1);
    v(1,0,32'h0,0,            1,20'h0,0,0,1);
    // err_clr in IDLE
    v(1,0,32'h0,1,            1,20'h0,0,0,0);
    // bad header with simultaneous clear: set wins; clear works in DISCARD
    v(1,1,32'hA500_001F,1,    1,20'h0,0,1,1);
    v(1,1,32'h0,1,            1,20'h0,0,1,0);
    v(1,1,32'h0,0,            1,20'h0,0,1,0);
    v(1,1,32'h0,0,            1,20'h0,0,1,0);
    v(1,1,32'h0,0,            1,20'h0,0,0,0, 1,F2);
    // last index 19; a sync-looking data word is still data
    v(1,1,32'hA500_0013,0,    1,20'h0,0,1,0);
    v(1,1,32'hA500_0001,0,    1,20'h0,0,1,0);
    v(1,1,32'h5555_5555,0,    1,20'h0,0,1,0);
    v(1,1,32'h6666_6666,0,    1,20'h0,0,1,0);
    v(1,1,32'h7777_7777,0,    0,20'h0,0,1,0, 1,F3);
    v(1,0,32'h0,0,            0,20'h80000,0,1,0);
    v(1,0,32'h0,0,            0,20'h80000,0,1,0);
    v(1,0,32'h0,0,            0,20'h0,1,1,0);
    v(1,0,32'h0,0,            1,20'h0,0,0,0, 1,F3);

    foreach (tbl[i]) begin
      step(tbl[i].rstn, tbl[i].vld, tbl[i].data, tbl[i].clr);
      outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].stb, tbl[i].dn, tbl[i].bsy, tbl[i].er);
      if (tbl[i].chkfd) chk($sformatf("vec%0d.fd", i), FrameData, tbl[i].fd);
    end

    // Backpressure: 3 idle cycles before every data word, idx 3.
    word(32'hA500_0003);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        step(1'b1, 1'b0, 32'h0, 1'b0);
        outs($sformatf("bp_gap%0d_%0d", k, g), 1, 20'h0, 0, 1, 0);
      end
      case (k)
        0: word(32'h1111_1111);
        1: word(32'h2222_2222);
        2: word(32'h3333_3333);
        default: word(32'h4444_4444);
      endcase
    end
    outs("bp_setup", 0, 20'h0, 0, 1, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0); outs("bp_stb0", 0, 20'h8, 0, 1, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0); outs("bp_stb1", 0, 20'h8, 0, 1, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0); outs("bp_hold", 0, 20'h0, 1, 1, 0);
    chk("bp_fd", FrameData, F1);
    step(1'b1, 1'b0, 32'h0, 1'b0); outs("bp_idle", 1, 20'h0, 0, 0, 0);

    // Reset during the first STROBE cycle, with err previously set.
    word(32'hA500_0019);
    for (int k = 0; k < 4; k++) word(32'h0);
    chk("rs_err_pre", 128'(err), 128'(1));
    word(32'hA500_0005);
    word(32'h0123_4567); word(32'h89AB_CDEF); word(32'h0F0F_0F0F); word(32'hF0F0_F0F0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    outs("rs_stb1", 0, 20'h20, 0, 1, 1);
    chk("rs_fd_pre", FrameData, F2);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    outs("rs_after", 0, 20'h0, 0, 0, 0);
    chk("rs_fd", FrameData, 128'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    outs("rs_release", 1, 20'h0, 0, 0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    outs("rs_quiet", 1, 20'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
